lvds_frame_writer: RTL and testbench
====================================

# lvds_frame_writer

Downstream of the LVDS receiver in the HFRC capture path. Takes the receiver's 64-bit packed pixel words and buffers them in a small FIFO. Drains them through a valid/ready write port into one of two frame buffers in external memory. Reports frame completion and returns `frame_buffer_rdy` to the receiver so it only starts a frame when a buffer is free.

## Interface
- `FIFO_DEPTH`, 16: entries of 64 bits; power of two, ≥4.
- `WORDS_PER_FRAME`, 32'd32768: 64-bit words per frame.
- `ADDR_W`, 32: memory byte-address width.
- `BASE_ADDR_0`, 32'h0000_0000: byte base of buffer 0.
- `BASE_ADDR_1`, 32'h0100_0000: byte base of buffer 1.

Ports:
- `CLK` in 1: LVDS slow clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ram_data` in 64: packed pixel word from the receiver.
- `ram_data_rdy` in 1: `ram_data` is valid this cycle; no backpressure.
- `write_to_lvds_fifo` in 1: the receiver has committed the current frame to capture.
- `new_frame_rdy` in 1: level; its rising edge coincides with the first data word of a frame.
- `frame_buffer_rdy` out 1: a free buffer is available and the block is idle.
- `mem_wr_valid` out 1 / `mem_wr_ready` in 1: write handshake.
- `mem_wr_addr` out ADDR_W: byte address of `mem_wr_data`.
- `mem_wr_data` out 64: data word.
- `frame_done` out 1: one-cycle pulse when the last word of a frame has been accepted by memory.
- `frame_done_sel` out 1: buffer index that completed; valid with `frame_done`.
- `frame_err` out 1: valid with `frame_done`; the frame lost words to overflow.
- `buf_release` in 2: one-cycle pulse per bit; the consumer frees buffer i.
- `overflow` out 1: sticky; set on any dropped word.
- `clear_overflow` in 1: clears `overflow`.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Reset values:** all outputs 0 except `frame_buffer_rdy`=1. `buf_full`=2'b00, `wr_sel`=0, all counters 0, state IDLE.
- **State machine:**
  - IDLE → CAPTURE when `ram_data_rdy && write_to_lvds_fifo && new_frame_rdy && !new_frame_rdy_d && !buf_full[wr_sel]`. That word is word 0 and is pushed. If the condition holds but `buf_full[wr_sel]`=1, the frame is ignored.
  - CAPTURE: push on every `ram_data_rdy`; `write_to_lvds_fifo` is not rechecked. Capture count increments per offered word, pushed or dropped. After word WORDS_PER_FRAME-1 is offered, go to FLUSH.
  - FLUSH: drain until drain count = number of words pushed and FIFO empty, then go to DONE.
  - DONE: one cycle. `frame_done`=1, `frame_done_sel`=`wr_sel`, `frame_err`=per-frame drop flag. On the exit edge, `buf_full[wr_sel]`←1 and `wr_sel` toggles. Return to IDLE.
- **Address:** `mem_wr_addr` = base(`wr_sel`) + (drain_count << 3), modulo 2^ADDR_W. drain_count increments per handshake and clears on entering CAPTURE.
- **FIFO full:**
  - A push with no pop in the same cycle is dropped; `overflow` and the frame drop flag are set.
  - Simultaneous push and pop when full succeeds.
  - Simultaneous push and pop when empty: the word is written and becomes visible next cycle (no fall-through).
- **`clear_overflow`:** if asserted in the same cycle as a new drop, the set wins.
- **`buf_release[i]`:** clears `buf_full[i]`. If it coincides with the DONE set of the same buffer, the set wins.
- **`frame_buffer_rdy`:** registered; equals (next state == IDLE) && !buf_full[next wr_sel].
- **`ram_data_rdy` in IDLE or FLUSH:** ignored and not counted as a drop.

## Timing
- Push at the edge of the `ram_data_rdy` cycle. `mem_wr_valid` rises at the earliest one cycle after the first push.
- `mem_wr_valid`/`addr`/`data` stay stable until a cycle with `mem_wr_ready`=1. Back-to-back handshakes give 1 word per cycle.
- `frame_done` is high the cycle after the final handshake. `frame_buffer_rdy` goes to 1 the cycle after DONE if the next buffer is free.
- **Reset mid-frame:** outputs and state clear immediately and asynchronously. Partial frame contents are abandoned and both buffers are marked free.

## Configuration
- `FRAME_PINGPONG_EN` defined: two buffers alternate via `wr_sel` as described.
- `FRAME_PINGPONG_EN` undefined:
  - `wr_sel` is constant 0 and `BASE_ADDR_1` is unused.
  - `buf_release[1]` is ignored and `frame_done_sel` is always 0.
  - `frame_buffer_rdy` stays 0 from DONE until `buf_release[0]`.

## Test plan
- Set WORDS_PER_FRAME=8 and `mem_wr_ready`=1. Send 8 words 0x1..0x8 starting on a `new_frame_rdy` rise. Required: writes at addresses 0x0..0x38 in order, `frame_done`=1 with sel 0 and err 0, then `frame_buffer_rdy`=1 with `wr_sel`=1.
- Second frame, no release: writes go to 0x0100_0000+. Third frame start is ignored while `buf_full`=2'b11 and `frame_buffer_rdy`=0. After `buf_release[0]`, the next frame is captured into buffer 0.
- Set FIFO_DEPTH=4, `mem_wr_ready`=0, and send 8 words. Required: `fifo_level`=4, 4 drops, `overflow`=1. Raise ready: 4 writes, then `frame_done` with `frame_err`=1. Assert `clear_overflow` together with a new drop: `overflow` stays 1.
- Toggle `mem_wr_ready` randomly: `mem_wr_addr`/`data` are held stable while valid and not ready, and the data sequence is preserved.
- Assert `reset_n`=0 after word 3 of 8: all outputs are at reset values that same cycle. After release, a fresh frame writes from BASE_ADDR_0.
- Build without `FRAME_PINGPONG_EN`: two frames both target 0x0, and the second waits for `buf_release[0]`.

Source files
------------

// File: rtl/lvds_frame_writer.sv
// lvds_frame_writer
//   Buffers 64-bit packed pixel words from the LVDS receiver in a small FIFO.
//   Drains them over a valid/ready write port into one of two frame buffers
//   in external memory. Reports frame completion and tells the receiver when
//   a buffer is free.
//
// Build option:
//   FRAME_PINGPONG_EN - when defined, frames alternate between BASE_ADDR_0
//                       and BASE_ADDR_1. When undefined, every frame targets
//                       buffer 0, and buf_release[1] is ignored.
//
// Ports:
//   CLK, reset_n          clock, asynchronous active-low reset
//   ram_data/_rdy         pixel word and its valid strobe (no backpressure)
//   write_to_lvds_fifo    receiver committed the current frame to capture
//   new_frame_rdy         level; its rising edge marks word 0 of a frame
//   frame_buffer_rdy      idle with a free buffer available
//   mem_wr_*              memory write handshake (byte address, 64-bit data)
//   frame_done/_sel/_err  one-cycle completion pulse, buffer index, lost-word flag
//   buf_release           per-buffer free pulse from the consumer
//   overflow/clear_overflow  sticky drop flag and its clear
//   fifo_level            current FIFO occupancy
module lvds_frame_writer #(
  parameter int unsigned       FIFO_DEPTH      = 16,
  parameter logic [31:0]       WORDS_PER_FRAME = 32'd32768,
  parameter int unsigned       ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR_0     = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] BASE_ADDR_1     = 32'h0100_0000
) (
  input  logic                          CLK,
  input  logic                          reset_n,
  input  logic [63:0]                   ram_data,
  input  logic                          ram_data_rdy,
  input  logic                          write_to_lvds_fifo,
  input  logic                          new_frame_rdy,
  output logic                          frame_buffer_rdy,
  output logic                          mem_wr_valid,
  input  logic                          mem_wr_ready,
  output logic [ADDR_W-1:0]             mem_wr_addr,
  output logic [63:0]                   mem_wr_data,
  output logic                          frame_done,
  output logic                          frame_done_sel,
  output logic                          frame_err,
  input  logic [1:0]                    buf_release,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_e;

  state_e             state_q, state_d;
  logic [63:0]        fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic [31:0]        cap_cnt_q, cap_cnt_d, push_cnt_q, push_cnt_d, drain_cnt_q, drain_cnt_d;
  logic               drop_flag_q, drop_flag_d;
  logic               overflow_q, overflow_d;
  logic               nfr_q;
  logic [1:0]         buf_full_q, buf_full_d, rel_mask, done_set;
  logic               frame_buffer_rdy_q;
  logic               wr_sel, wr_sel_nx;
  logic               start, push_req, push_ok, pop, drop, fifo_full, fifo_empty;

`ifdef FRAME_PINGPONG_EN
  logic wr_sel_q;
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) wr_sel_q <= 1'b0;
    else          wr_sel_q <= wr_sel_nx;
  end
  assign wr_sel    = wr_sel_q;
  assign wr_sel_nx = (state_q == DONE) ? ~wr_sel_q : wr_sel_q;
  assign rel_mask  = 2'b11;
`else
  assign wr_sel    = 1'b0;
  assign wr_sel_nx = 1'b0;
  assign rel_mask  = 2'b01;
`endif

  assign fifo_empty = (lvl_q == '0);
  assign fifo_full  = (lvl_q == LVL_W'(FIFO_DEPTH));
  assign start      = ram_data_rdy && write_to_lvds_fifo && new_frame_rdy && !nfr_q
                      && !buf_full_q[wr_sel];
  assign push_req   = ((state_q == IDLE) && start) || ((state_q == CAPTURE) && ram_data_rdy);
  assign pop        = !fifo_empty && mem_wr_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;
  assign done_set   = (state_q == DONE) ? (2'b01 << wr_sel) : 2'b00;
  // Release and DONE on the same buffer: the set is applied last so it wins.
  assign buf_full_d = (buf_full_q & ~(buf_release & rel_mask)) | done_set;

  // State register
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (WORDS_PER_FRAME == 32'd1) ? FLUSH : CAPTURE;
      CAPTURE: if (ram_data_rdy && (cap_cnt_q == WORDS_PER_FRAME - 32'd1)) state_d = FLUSH;
      // Looking at the post-handshake counts lets DONE follow the last write directly.
      FLUSH:   if ((drain_cnt_d == push_cnt_q) && (lvl_d == '0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_wr_valid     = !fifo_empty;
    mem_wr_data      = '0;
    mem_wr_addr      = '0;
    if (!fifo_empty) begin
      mem_wr_data = fifo_q[rd_ptr_q];
      mem_wr_addr = (wr_sel ? BASE_ADDR_1 : BASE_ADDR_0) + (ADDR_W'(drain_cnt_q) << 3);
    end
    frame_done       = (state_q == DONE);
    frame_done_sel   = frame_done && wr_sel;
    frame_err        = frame_done && drop_flag_q;
    frame_buffer_rdy = frame_buffer_rdy_q;
    overflow         = overflow_q;
    fifo_level       = lvl_q;
  end

  // Datapath next-state
  always_comb begin
    wr_ptr_d    = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    lvl_d       = lvl_q;
    unique case ({push_ok, pop})
      2'b10:   lvl_d = lvl_q + LVL_W'(1);
      2'b01:   lvl_d = lvl_q - LVL_W'(1);
      default: lvl_d = lvl_q;
    endcase
    cap_cnt_d   = cap_cnt_q;
    push_cnt_d  = push_cnt_q;
    drain_cnt_d = drain_cnt_q;
    drop_flag_d = drop_flag_q;
    if ((state_q == IDLE) && start) begin
      cap_cnt_d   = 32'd1;
      push_cnt_d  = 32'd1;
      drain_cnt_d = '0;
      drop_flag_d = 1'b0;
    end else begin
      if ((state_q == CAPTURE) && ram_data_rdy) cap_cnt_d = cap_cnt_q + 32'd1;
      if (push_ok) push_cnt_d  = push_cnt_q + 32'd1;
      if (pop)     drain_cnt_d = drain_cnt_q + 32'd1;
      if (drop)    drop_flag_d = 1'b1;
    end
    overflow_d = drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      lvl_q              <= '0;
      cap_cnt_q          <= '0;
      push_cnt_q         <= '0;
      drain_cnt_q        <= '0;
      drop_flag_q        <= 1'b0;
      overflow_q         <= 1'b0;
      nfr_q              <= 1'b0;
      buf_full_q         <= '0;
      frame_buffer_rdy_q <= 1'b1;
    end else begin
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      lvl_q              <= lvl_d;
      cap_cnt_q          <= cap_cnt_d;
      push_cnt_q         <= push_cnt_d;
      drain_cnt_q        <= drain_cnt_d;
      drop_flag_q        <= drop_flag_d;
      overflow_q         <= overflow_d;
      nfr_q              <= new_frame_rdy;
      buf_full_q         <= buf_full_d;
      frame_buffer_rdy_q <= (state_d == IDLE) && !buf_full_d[wr_sel_nx];
    end
  end

  // FIFO storage carries no reset; occupancy and pointers decide what is visible.
  always_ff @(posedge CLK) begin
    if (push_ok) fifo_q[wr_ptr_q] <= ram_data;
  end

endmodule

// File: tb/tb_lvds_frame_writer.sv
// tb_lvds_frame_writer
//   Randomized bench for lvds_frame_writer (FIFO_DEPTH=4, 8 words per frame)
//   with a queue-based reference model. Follows FRAME_PINGPONG_EN the same
//   way the design does.
module tb_lvds_frame_writer;

  localparam int unsigned DEPTH = 4;
  localparam int          WPF   = 8;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0100_0000;
`ifdef FRAME_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        reset_n;
  logic [63:0] ram_data;
  logic        ram_data_rdy, write_to_lvds_fifo, new_frame_rdy;
  logic        frame_buffer_rdy, mem_wr_valid, mem_wr_ready;
  logic [31:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic        frame_done, frame_done_sel, frame_err;
  logic [1:0]  buf_release;
  logic        overflow, clear_overflow;
  logic [2:0]  fifo_level;

  lvds_frame_writer #(
    .FIFO_DEPTH      (DEPTH),
    .WORDS_PER_FRAME (32'(WPF)),
    .ADDR_W          (32),
    .BASE_ADDR_0     (BASE0),
    .BASE_ADDR_1     (BASE1)
  ) dut (
    .CLK                (CLK),
    .reset_n            (reset_n),
    .ram_data           (ram_data),
    .ram_data_rdy       (ram_data_rdy),
    .write_to_lvds_fifo (write_to_lvds_fifo),
    .new_frame_rdy      (new_frame_rdy),
    .frame_buffer_rdy   (frame_buffer_rdy),
    .mem_wr_valid       (mem_wr_valid),
    .mem_wr_ready       (mem_wr_ready),
    .mem_wr_addr        (mem_wr_addr),
    .mem_wr_data        (mem_wr_data),
    .frame_done         (frame_done),
    .frame_done_sel     (frame_done_sel),
    .frame_err          (frame_err),
    .buf_release        (buf_release),
    .overflow           (overflow),
    .clear_overflow     (clear_overflow),
    .fifo_level         (fifo_level)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int rdy_mode = 1;  // 0: ready low, 1: ready high, 2: random

  // Reference model: a queue for the FIFO plus per-frame bookkeeping.
  logic [63:0] q[$];
  int   offered, pushed, written;
  bit   busy, capturing, done_now, ferr, ovf, fbr, sel, nfr_prev;
  bit [1:0] full;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    offered = 0; pushed = 0; written = 0;
    busy = 0; capturing = 0; done_now = 0; ferr = 0; ovf = 0;
    fbr = 1; sel = 0; nfr_prev = 0; full = 2'b00;
  endtask

  task automatic check_outputs();
    logic [31:0] ea;
    ea = (sel ? BASE1 : BASE0) + 32'(written) * 32'd8;
    check("valid", mem_wr_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("addr", mem_wr_addr, ea);
      check("data", mem_wr_data, q[0]);
    end
    check("level", fifo_level, q.size());
    check("done", frame_done, done_now);
    if (done_now) begin
      check("done_sel", frame_done_sel, sel);
      check("done_err", frame_err, ferr);
    end
    check("overflow", overflow, ovf);
    check("fbuf_rdy", frame_buffer_rdy, fbr);
  endtask

  task automatic model_step();
    bit pop, start, push, drop, was_flush, was_done;
    int sz;
    sz        = q.size();
    pop       = (sz > 0) && mem_wr_ready;
    start     = !busy && !done_now && ram_data_rdy && write_to_lvds_fifo &&
                new_frame_rdy && !nfr_prev && !full[sel];
    push      = start || (capturing && ram_data_rdy);
    drop      = push && (sz == DEPTH) && !pop;
    was_flush = busy && !capturing;
    was_done  = done_now;
    if (pop) begin void'(q.pop_front()); written++; end
    if (push && !drop) begin q.push_back(ram_data); pushed++; end
    if (drop) begin ovf = 1; ferr = 1; end
    else if (clear_overflow) ovf = 0;
    full = full & ~(buf_release & (PP ? 2'b11 : 2'b01));
    if (was_done) begin
      full[sel] = 1;
      if (PP) sel = !sel;
      done_now = 0;
    end
    if (start) begin
      busy = 1; capturing = (WPF > 1); offered = 1; pushed = 1; written = 0; ferr = 0;
    end else if (capturing && ram_data_rdy) begin
      offered++;
      if (offered == WPF) capturing = 0;
    end else if (was_flush && written == pushed) begin
      busy = 0; done_now = 1;
    end
    fbr = !busy && !done_now && !full[sel];
    nfr_prev = new_frame_rdy;
  endtask

  task automatic tick();
    if (rdy_mode == 2) mem_wr_ready = 1'($urandom_range(0, 1));
    else               mem_wr_ready = (rdy_mode == 1);
    check_outputs();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    ram_data_rdy = 0; write_to_lvds_fifo = 0; new_frame_rdy = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_frame(input int nwords, input int gap_pct, input int clr_idx, input bit seq);
    for (int i = 0; i < nwords; i++) begin
      if (i > 0) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(0, 99) >= gap_pct) break;
          ram_data_rdy = 0;
          tick();
        end
      end
      ram_data_rdy       = 1;
      write_to_lvds_fifo = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      new_frame_rdy      = 1;
      ram_data           = seq ? 64'(i + 1) : {$urandom, $urandom};
      clear_overflow     = (i == clr_idx);
      tick();
      clear_overflow     = 0;
    end
    ram_data_rdy = 0; write_to_lvds_fifo = 0; new_frame_rdy = 0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (busy || done_now); i++) tick();
    check("wait_idle", busy || done_now, 0);
  endtask

  task automatic release_bufs(input logic [1:0] m);
    buf_release = m;
    tick();
    buf_release = 2'b00;
  endtask

  initial begin
    reset_n = 0; ram_data = '0; ram_data_rdy = 0; write_to_lvds_fifo = 0;
    new_frame_rdy = 0; mem_wr_ready = 0; buf_release = 2'b00; clear_overflow = 0;
    model_reset();
    @(posedge CLK); #1;
    check_outputs();
    reset_n = 1;
    idle(2);

    // Sequential frame, always ready: buffer 0 at 0x0..0x38.
    rdy_mode = 1;
    send_frame(8, 0, -1, 1'b1);
    wait_idle(50);
    idle(1);

    // Second frame without release, then a third with no free buffer.
    send_frame(8, 30, -1, 1'b0);
    wait_idle(80);
    idle(1);
    send_frame(8, 0, -1, 1'b0);
    wait_idle(80);
    check("fbuf_rdy_busy", frame_buffer_rdy, 0);
    release_bufs(2'b01);
    idle(1);
    send_frame(8, 20, -1, 1'b0);
    wait_idle(80);

    // Overflow: memory stalled during an 8-word burst into a 4-deep FIFO.
    release_bufs(2'b11);
    idle(2);
    rdy_mode = 0;
    send_frame(8, 0, -1, 1'b0);
    idle(2);
    check("level_full", fifo_level, 4);
    check("overflow_set", overflow, 1);
    rdy_mode = 1;
    wait_idle(80);
    clear_overflow = 1;
    tick();
    clear_overflow = 0;
    check("overflow_clr", overflow, 0);
    release_bufs(2'b11);
    idle(1);
    rdy_mode = 0;
    send_frame(8, 0, 7, 1'b0);   // clear coincides with the last drop
    check("overflow_keep", overflow, 1);
    rdy_mode = 1;
    wait_idle(80);

    // Random ready and random word gaps.
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      release_bufs((f % 2 == 0) ? 2'b11 : 2'($urandom_range(0, 3)));
      idle(2);
      send_frame(8, 40, -1, 1'b0);
      wait_idle(300);
    end

    // Reset in the middle of a frame.
    rdy_mode = 1;
    release_bufs(2'b11);
    idle(2);
    send_frame(3, 0, -1, 1'b0);
    reset_n = 0;
    #1;
    check("rst_valid", mem_wr_valid, 0);
    check("rst_addr", mem_wr_addr, 0);
    check("rst_data", mem_wr_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_done", frame_done, 0);
    check("rst_sel", frame_done_sel, 0);
    check("rst_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_fbuf_rdy", frame_buffer_rdy, 1);
    model_reset();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    reset_n = 1;
    idle(2);
    send_frame(8, 0, -1, 1'b1);
    wait_idle(80);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
